// File: rtl/noc_pkg.sv
// +-------------------------------------------------------------------+
// | noc_pkg: shared NoC egress/response constants and arbiter states. |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
`default_nettype none

package noc_pkg;

  localparam logic [7:0] NOC_NOP_BYTE = 8'h00;

  localparam logic [2:0] NOC_OP_RD_RSP = 3'b011;
  localparam logic [2:0] NOC_OP_WR_RSP = 3'b100;
  localparam logic [2:0] NOC_OP_MSG    = 3'b101;

  typedef enum logic [0:0] {
    ARB = 1'b0,
    FWD = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/noc_egress_arb_rr_pick.sv
// +-------------------------------------------------------------------+
// | rr_pick: round-robin pick, first set bit of req at or above ptr.  |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    w_dbl = {req, req};
    w_rot = w_dbl[ptr +: N];
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDX_W'(k);
    end
    w_sum = {1'b0, ptr} + {1'b0, w_off};
    if (w_sum >= (IDX_W + 1)'(N)) w_sum = w_sum - (IDX_W + 1)'(N);
    gnt_idx = w_sum[IDX_W-1:0];
    any     = |req;
  end

endmodule

`default_nettype wire

// File: rtl/noc_egress_arb.sv
// +-------------------------------------------------------------------+
// | noc_egress_arb: packet-atomic round-robin arbiter for NoC egress. |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
`default_nettype none

module noc_egress_arb
  import noc_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [N-1:0]     req_ctl,
  input  logic [8*N-1:0]   req_data,
  input  logic [N-1:0]     req_last,
  output logic [N-1:0]     req_ready,
  output logic             noc_from_dev_ctl,
  output logic [7:0]       noc_from_dev_data,
  output logic             busy,
  output logic [IDX_W-1:0] grant_id,
  output logic [N-1:0]     hdr_err,
  output logic [N-1:0]     gap_err,
  input  logic             err_clr
);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N - 1);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_first;
  logic             r_ctl;
  logic [7:0]       r_data;
  logic [N-1:0]     r_hdr_err;
  logic [N-1:0]     r_gap_err;

  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic             w_cur_valid;
  logic             w_sel_ctl;
  logic             w_sel_last;
  logic [7:0]       w_sel_data;
  logic             w_accept;
  logic [N-1:0]     w_hdr_set;
  logic [N-1:0]     w_gap_set;
  logic [IDX_W-1:0] w_next_ptr;

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_pick_idx),
    .any     (w_pick_any)
  );

  // req_ready depends only on state, grant and valid: no data/ctl/last path.
  always_comb begin
    w_cur_valid = req_valid[r_grant];
    w_sel_ctl   = req_ctl[r_grant];
    w_sel_last  = req_last[r_grant];
    w_sel_data  = req_data[8*r_grant +: 8];
    w_accept    = (r_state == FWD) && w_cur_valid;

    req_ready = '0;
    if (r_state == FWD) req_ready[r_grant] = w_cur_valid;

    w_hdr_set = '0;
    w_gap_set = '0;
    if (w_accept && r_first && !w_sel_ctl) w_hdr_set[r_grant] = 1'b1;
    if ((r_state == FWD) && !r_first && !w_cur_valid) w_gap_set[r_grant] = 1'b1;

    w_next_ptr = (r_grant == c_last_idx) ? '0 : r_grant + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ARB;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_first  <= 1'b1;
      r_ctl    <= 1'b1;
      r_data   <= NOC_NOP_BYTE;
    end else begin
      r_ctl  <= 1'b1;
      r_data <= NOC_NOP_BYTE;
      case (r_state)
        ARB: begin
          if (w_pick_any) begin
            r_grant <= w_pick_idx;
            r_first <= 1'b1;
            r_state <= FWD;
          end
        end
        FWD: begin
          if (w_accept) begin
            r_ctl   <= w_sel_ctl;
            r_data  <= w_sel_data;
            r_first <= 1'b0;
            if (w_sel_last) begin
              r_state  <= ARB;
              r_rr_ptr <= w_next_ptr;
              r_first  <= 1'b1;
            end
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  // Set has priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hdr_err <= '0;
      r_gap_err <= '0;
    end else begin
      r_hdr_err <= (err_clr ? '0 : r_hdr_err) | w_hdr_set;
      r_gap_err <= (err_clr ? '0 : r_gap_err) | w_gap_set;
    end
  end

  assign noc_from_dev_ctl  = r_ctl;
  assign noc_from_dev_data = r_data;
  assign busy              = (r_state == FWD);
  assign grant_id          = r_grant;
  assign hdr_err           = r_hdr_err;
  assign gap_err           = r_gap_err;

endmodule

`default_nettype wire

// File: doc/noc_egress_arb.md
# noc_egress_arb

Packet-atomic round-robin arbiter that shares the single byte-wide NoC egress channel (`noc_from_dev_ctl` / `noc_from_dev_data`) between N response sources. Typical sources are the write/read-response generator, the message generator and future DMA-status sources. It sits between those sources and the NoC pins, and grants whole packets so bytes of different packets never interleave. It also polices source protocol (header marking, contiguous streaming) with sticky error flags.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `IDX_W`, default `$clog2(N)`: width of the grant index.
- `clk`  in  1  clock.
- `rst`  in  1  reset. Asynchronous, active-high; clock is `clk`.
- `req_valid`  in  N  requester i has a byte presented.
- `req_ctl`  in  N  control bit of the presented byte. It is 1 on the header byte only.
- `req_data`  in  N×8  presented byte, packed as `[8*i+7:8*i]`.
- `req_last`  in  N  presented byte is the final byte of its packet.
- `req_ready`  out  N  byte accepted this cycle, when `valid && ready`.
- `noc_from_dev_ctl`  out  1  egress control bit. It is 1 for headers and for NOP.
- `noc_from_dev_data`  out  8  egress byte.
- `busy`  out  1  a packet is in flight (state FWD).
- `grant_id`  out  IDX_W  index of the current or most recent grantee.
- `hdr_err`  out  N  sticky. The first byte of a packet arrived with `req_ctl=0`.
- `gap_err`  out  N  sticky. `req_valid` dropped mid-packet.
- `err_clr`  in  1  synchronous clear of `hdr_err` and `gap_err`.

## Operation
- Two-state FSM: ARB and FWD. Reset state is ARB.
- **ARB**
  - If any `req_valid` is set, pick the first set bit scanning from `rr_ptr` upward, modulo N.
  - Register the winner into `grant_id` and go to FWD.
  - `req_ready` is all-zero in ARB.
- **FWD**
  - `req_ready[grant_id] = req_valid[grant_id]`. All other ready bits are 0.
  - An accepted byte is registered to the egress outputs on the next clock.
  - On accept with `req_last=1`: return to ARB, set `rr_ptr <= grant_id+1` modulo N, and set `first <= 1`.
- **Header check.** `first` is set on entry to FWD. On the first accepted byte:
  - if `req_ctl=0`, set `hdr_err[grant_id]`;
  - the byte is forwarded unchanged;
  - clear `first`.
- **Gap handling.** If in FWD with `first=0` and `req_valid[grant_id]=0`:
  - the egress outputs NOP (`ctl=1`, `data=8'h00`);
  - set `gap_err[grant_id]`;
  - stay in FWD with the grant held.
  - If `first=1`, the cycle is a plain wait with no error.
- **Egress when nothing is accepted:** NOP (`ctl=1`, `data=0`).
- **Single-byte packet** (`last` on the first byte) is legal: one FWD cycle, then back to ARB.
- **Error flags**
  - Set and clear in the same cycle: set wins.
  - `err_clr` does not affect the FSM.
- **Non-grantees** may hold `valid` indefinitely. Round-robin order guarantees each is served within N−1 packets.
- **Reset mid-packet:** everything returns to reset values and the partial packet is abandoned. Sources must also be reset.

## Timing
- **Reset values:**
  - `noc_from_dev_ctl=1`, `noc_from_dev_data=0`;
  - `req_ready=0`, `busy=0`, `grant_id=0`;
  - `hdr_err=0`, `gap_err=0`;
  - `rr_ptr=0`, `first=1`.
- **Latency:**
  - A valid rising in ARB at cycle t is granted at edge t.
  - `req_ready` is high during t+1.
  - The header appears on egress after edge t+1.
  - This gives 2 cycles from valid to egress, and 1 cycle from accept to egress.
- **Inter-packet gap:** exactly one NOP cycle between the last byte of packet k and the header of packet k+1 (the ARB cycle), including when the same requester sends back-to-back.
- **Throughput:** L-byte packet costs L+1 cycles.
- `req_ready` is combinational from state, `grant_id` and `req_valid`. It has no path from `req_data`, `req_ctl` or `req_last`.

## Structure
- A shared package `noc_pkg` holds:
  - `NOC_NOP_BYTE = 8'h00`;
  - header opcode constants (3'b011 read-response, 3'b100 write-response, 3'b101 message);
  - the FSM enum `arb_state_t {ARB, FWD}`.
  - The receive/response interface reuses the same constants.
- Sub-module `rr_pick #(N)`: combinational rotate, priority-encode and un-rotate. It takes `req` and `ptr` and returns `gnt_idx` and `any`. It is reusable for other shared NoC resources.

## Test plan
- **Reset mid-packet:** assert `rst` during byte 3 of a 6-byte packet -> all outputs at reset values, then a fresh packet from req2 is forwarded intact with its header 2 cycles after valid.
- **Single requester:** req0 sends 5 bytes `{ctl1:8'h04, 8'h11, 8'h22, 8'h33, 8'h08}` -> egress shows NOP, NOP, then the 5 bytes with ctl 1,0,0,0,0, then NOP. `busy` is high for 5 cycles.
- **Round-robin:** all 4 requesters hold 4-byte packets continuously -> grant order 0,1,2,3,0,…, with one NOP between packets and no interleaving.
- **Gap:** req1 drops valid for 2 cycles after byte 2 -> 2 NOP bytes inserted, `gap_err=4'b0010`, packet completes, and `err_clr` returns it to 0.
- **Header check:** req3's first byte has `ctl=0` -> `hdr_err[3]=1`, byte forwarded, no other flag set.
- **Single-byte packets back-to-back from req0 and req1** -> egress ctl-1 byte, NOP, ctl-1 byte, and `grant_id` toggles 0→1.
